// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
package fifo_rd_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } pack_state_t;

    function automatic int lane_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_idle_timer.sv
// Idle-cycle counter that flags when a partially filled word has waited too long.
// Used by fifo_rd_packer only when FIFO_RD_PACKER_TIMEOUT_EN is defined.
module pack_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expire_o
);

    localparam int CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the idle cycle that would complete TIMEOUT idle edges since the last pop.
    assign expire_o = count_en_i && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops RATIO narrow words from a show-ahead FIFO and presents them packed on a valid/ready stream.
// Optional partial-word flush after an idle period is enabled by FIFO_RD_PACKER_TIMEOUT_EN.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   fifo_empty_i,
    input  logic [WIDTH-1:0]       fifo_dout_i,
    output logic                   fifo_pop_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [WIDTH*RATIO-1:0] m_data_o,
    output logic [RATIO-1:0]       m_keep_o
);

    localparam int IDX_W = lane_idx_w(RATIO);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(RATIO - 1);

    if (RATIO < 1 || TIMEOUT < 1) begin : gBadParams
        $error("fifo_rd_packer: RATIO and TIMEOUT must both be at least 1");
    end

    pack_state_t            state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WIDTH*RATIO-1:0] data_q, data_d;
    logic [RATIO-1:0]       keep_q, keep_d;
    logic                   popEn;
    logic                   handshake;
    logic                   timerExpire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // RATIO==1 keeps streaming in FULL when a new word arrives with the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if ((popEn && (idx_q == LastIdx)) || timerExpire) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (handshake && !(popEn && (RATIO == 1))) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        popEn = 1'b0;
        if (!rst_i && !fifo_empty_i) begin
            popEn = (state_q == FILL) || m_ready_i;
        end
    end

    assign fifo_pop_o = popEn;
    assign m_valid_o  = (state_q == FULL);
    assign handshake  = m_valid_o && m_ready_i;
    assign m_data_o   = data_q;
    assign m_keep_o   = keep_q;

    always_comb begin
        data_d = data_q;
        keep_d = keep_q;
        idx_d  = idx_q;
        if (state_q == FILL) begin
            if (popEn) begin
                for (int i = 0; i < RATIO; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        data_d[i*WIDTH +: WIDTH] = fifo_dout_i;
                        keep_d[i]                = 1'b1;
                    end
                end
                idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
            end else if (timerExpire) begin
                idx_d = '0;
            end
        end else if (handshake) begin
            data_d = '0;
            keep_d = '0;
            idx_d  = '0;
            // A word popped during the handshake starts the next packed word in lane 0.
            if (popEn) begin
                data_d[WIDTH-1:0] = fifo_dout_i;
                keep_d[0]         = 1'b1;
                idx_d             = (RATIO > 1) ? IDX_W'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            keep_q <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            keep_q <= keep_d;
            idx_q  <= idx_d;
        end
    end

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    logic timerCountEn;
    logic timerClear;

    assign timerCountEn = (state_q == FILL) && (idx_q != '0) && !popEn;
    assign timerClear   = popEn || timerExpire;

    pack_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) uIdleTimer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (timerClear),
        .count_en_i (timerCountEn),
        .expire_o   (timerExpire)
    );
`else
    assign timerExpire = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed self-checking bench for fifo_rd_packer with WIDTH=8, RATIO=4, TIMEOUT=16.
module tb_fifo_rd_packer;

   localparam int WIDTH   = 8;
   localparam int RATIO   = 4;
   localparam int TIMEOUT = 16;

   logic                   clk;
   logic                   rst;
   logic                   fifoEmpty;
   logic [WIDTH-1:0]       fifoDout;
   logic                   fifoPop;
   logic                   mValid;
   logic                   mReady;
   logic [WIDTH*RATIO-1:0] mData;
   logic [RATIO-1:0]       mKeep;

   logic [WIDTH-1:0] fifoMem [0:255];
   int wrPtr = 0;
   int rdPtr = 0;
   int emptyPops = 0;
   int testsRun = 0;
   int testsFailed = 0;

   fifo_rd_packer #(
      .WIDTH   (WIDTH),
      .RATIO   (RATIO),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .fifo_empty_i (fifoEmpty),
      .fifo_dout_i  (fifoDout),
      .fifo_pop_o   (fifoPop),
      .m_valid_o    (mValid),
      .m_ready_i    (mReady),
      .m_data_o     (mData),
      .m_keep_o     (mKeep)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Show-ahead FIFO model: head word is visible whenever the FIFO is not empty
   assign fifoEmpty = (rdPtr == wrPtr);
   assign fifoDout  = fifoEmpty ? '0 : fifoMem[rdPtr[7:0]];

   // FIFO read side consumes the head word when the DUT pops at a clock edge
   always @(posedge clk) begin
      if (fifoPop) begin
         if (fifoEmpty) emptyPops <= emptyPops + 1;
         else           rdPtr <= rdPtr + 1;
      end
   end

   // Global watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Push one word into the FIFO model
   task automatic applyStimulus(input logic [WIDTH-1:0] word);
      fifoMem[wrPtr[7:0]] = word;
      wrPtr = wrPtr + 1;
   endtask

   // Compare one observed value against the bench's expectation
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance to the next falling edge and let combinational outputs settle
   task automatic stepCycle();
      @(negedge clk);
      #1;
   endtask

   // Wait (bounded) for m_valid, returning the number of cycles it took
   task automatic waitValid(input int budget, output int cycles);
      cycles = 0;
      while (!mValid && cycles < budget) begin
         stepCycle();
         cycles++;
      end
   endtask

   int cycles;
   int validSeen;
   int popSeen;
   int startPtr;

   // Directed test sequence
   initial begin
      rst    = 1'b1;
      mReady = 1'b0;
      applyStimulus(8'h11);
      stepCycle();
      stepCycle();
      checkOutput("rst_pop", 64'(fifoPop), 64'h0);
      checkOutput("rst_valid", 64'(mValid), 64'h0);
      checkOutput("rst_keep", 64'(mKeep), 64'h0);
      checkOutput("rst_data", 64'(mData), 64'h0);

      // Test 1: four words packed, single-cycle valid with ready high
      @(negedge clk);
      rst    = 1'b0;
      mReady = 1'b1;
      startPtr = rdPtr;
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      applyStimulus(8'h44);
      #1;
      waitValid(20, cycles);
      checkOutput("t1_latency", 64'(cycles), 64'd4);
      checkOutput("t1_pops", 64'(rdPtr - startPtr), 64'd4);
      checkOutput("t1_data", 64'(mData), 64'h44332211);
      checkOutput("t1_keep", 64'(mKeep), 64'hF);
      stepCycle();
      checkOutput("t1_valid_drop", 64'(mValid), 64'h0);
      checkOutput("t1_keep_clear", 64'(mKeep), 64'h0);

      // Test 2: backpressure holds the word and blocks pops
      mReady = 1'b0;
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      applyStimulus(8'h44);
      applyStimulus(8'h55);
      #1;
      waitValid(20, cycles);
      checkOutput("t2_latency", 64'(cycles), 64'd4);
      for (int i = 0; i < 5; i++) begin
         checkOutput("t2_hold_pop", 64'(fifoPop), 64'h0);
         checkOutput("t2_hold_valid", 64'(mValid), 64'h1);
         checkOutput("t2_hold_data", 64'(mData), 64'h44332211);
         stepCycle();
      end
      mReady = 1'b1;
      #1;
      checkOutput("t2_release_pop", 64'(fifoPop), 64'h1);
      stepCycle();
      checkOutput("t2_after_valid", 64'(mValid), 64'h0);
      checkOutput("t2_after_data", 64'(mData), 64'h00000055);
      checkOutput("t2_after_keep", 64'(mKeep), 64'h1);
      applyStimulus(8'h66);
      applyStimulus(8'h77);
      applyStimulus(8'h88);
      #1;
      waitValid(20, cycles);
      checkOutput("t2_second_valid", 64'(mValid), 64'h1);
      checkOutput("t2_second_data", 64'(mData), 64'h88776655);
      checkOutput("t2_second_keep", 64'(mKeep), 64'hF);
      stepCycle();
      checkOutput("t2_end_valid", 64'(mValid), 64'h0);

      // Test 3: preloaded FIFO streams eight pops back to back
      for (int i = 1; i <= 8; i++) applyStimulus(WIDTH'(8'h11 * i));
      #1;
      for (int k = 0; k <= 8; k++) begin
         checkOutput("t3_pop", 64'(fifoPop), (k < 8) ? 64'h1 : 64'h0);
         if (k == 4) begin
            checkOutput("t3_first_valid", 64'(mValid), 64'h1);
            checkOutput("t3_first_data", 64'(mData), 64'h44332211);
         end
         if (k == 5) checkOutput("t3_mid_valid", 64'(mValid), 64'h0);
         if (k == 8) begin
            checkOutput("t3_second_valid", 64'(mValid), 64'h1);
            checkOutput("t3_second_data", 64'(mData), 64'h88776655);
         end
         stepCycle();
      end
      checkOutput("t3_end_valid", 64'(mValid), 64'h0);

      // Test 4: partial word of two lanes, then the FIFO runs dry
      applyStimulus(8'hAA);
      applyStimulus(8'hBB);
      #1;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
      repeat (TIMEOUT + 1) stepCycle();
      checkOutput("t4_pre_flush_valid", 64'(mValid), 64'h0);
      stepCycle();
      checkOutput("t4_flush_valid", 64'(mValid), 64'h1);
      checkOutput("t4_flush_data", 64'(mData), 64'h0000BBAA);
      checkOutput("t4_flush_keep", 64'(mKeep), 64'h3);
      stepCycle();
      checkOutput("t4_flush_done", 64'(mValid), 64'h0);
`else
      validSeen = 0;
      for (int i = 0; i < 100; i++) begin
         stepCycle();
         if (mValid) validSeen++;
      end
      checkOutput("t4_no_flush", 64'(validSeen), 64'h0);
      checkOutput("t4_partial_keep", 64'(mKeep), 64'h3);
      checkOutput("t4_partial_data", 64'(mData), 64'h0000BBAA);
`endif

      // Discard any leftover partial word before the next tests
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_keep", 64'(mKeep), 64'h0);

      // Test 6: empty FIFO with ready toggling never pops or produces output
      popSeen   = 0;
      validSeen = 0;
      for (int i = 0; i < 20; i++) begin
         mReady = ~mReady;
         #1;
         if (fifoPop) popSeen++;
         if (mValid)  validSeen++;
         stepCycle();
      end
      checkOutput("t6_pops", 64'(popSeen), 64'h0);
      checkOutput("t6_valid", 64'(validSeen), 64'h0);

      // Test 5: reset mid-word discards the partial, then a fresh word packs cleanly
      mReady = 1'b1;
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      #1;
      stepCycle();
      stepCycle();
      checkOutput("t5_partial_keep", 64'(mKeep), 64'h3);
      checkOutput("t5_partial_data", 64'(mData), 64'h00000201);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t5_rst_valid", 64'(mValid), 64'h0);
      checkOutput("t5_rst_keep", 64'(mKeep), 64'h0);
      checkOutput("t5_rst_data", 64'(mData), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(8'h0A);
      applyStimulus(8'h0B);
      applyStimulus(8'h0C);
      applyStimulus(8'h0D);
      #1;
      waitValid(20, cycles);
      checkOutput("t5_latency", 64'(cycles), 64'd4);
      checkOutput("t5_data", 64'(mData), 64'h0D0C0B0A);
      checkOutput("t5_keep", 64'(mKeep), 64'hF);
      stepCycle();
      checkOutput("t5_end_valid", 64'(mValid), 64'h0);

      checkOutput("pop_on_empty", 64'(emptyPops), 64'h0);
      checkOutput("fifo_drained", 64'(wrPtr - rdPtr), 64'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
